// File: rtl/line_streamer.sv
// -----------------------------------------------------------------------------
// line_streamer
//
// Fetches one line of (lhs,rhs) character pairs from the character-pair
// memory and streams them over a valid/ready interface. A line is described by
// a {length,start} descriptor taken from the line-pointer table; the block
// issues one memory read per cycle while it has credit, tracks reads in
// flight through a MEM_LAT-deep pipe, and parks returned data in a small FIFO
// so the consumer can apply backpressure without losing or repeating pairs.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   start            level; sampled only in IDLE, launches one line
//   abort            drop the current line and return to IDLE
//   pointer_addr     descriptor {len[LEN_W-1:0], start[ADDR_W-1:0]}
//   mem_addr/mem_en  read address and read strobe (one pair per strobe)
//   mem_dout         read data {lhs,rhs}, valid MEM_LAT cycles after mem_en
//   out_valid/out_ready   output handshake; lhs/rhs/out_last qualify it
//   out_last         marks the final pair of the line
//   busy             any state other than IDLE
//   done             one-cycle pulse when a line completes normally
//   chars_remaining  pairs not yet issued to memory
//   which_state      0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
// -----------------------------------------------------------------------------
module line_streamer #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 10,
    parameter int CHAR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_W+ADDR_W-1:0] pointer_addr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_en,
    input  logic [2*CHAR_W-1:0]     mem_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHAR_W-1:0]       lhs,
    output logic [CHAR_W-1:0]       rhs,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_W-1:0]        chars_remaining,
    output logic [1:0]              which_state
);

    // Enough FIFO space to cover every read in flight plus a head entry and
    // one spare, which is what sustains one pair per cycle with out_ready=1.
    localparam int FIFO_DEPTH = MEM_LAT + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = $clog2(MEM_LAT + FIFO_DEPTH + 1);
    localparam int ENTRY_W    = 2 * CHAR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    remaining_q;
    logic                done_q;

    // In-flight reads: bit i set means a read issued i+1 cycles ago is
    // still on its way back; the top stage lines up with valid mem_dout.
    logic [MEM_LAT-1:0]  pipe_valid_q;
    logic [MEM_LAT-1:0]  pipe_last_q;

    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    fifo_count;

    logic [ADDR_W-1:0]   desc_start;
    logic [LEN_W-1:0]    desc_len;
    logic [OCC_W-1:0]    inflight_cnt;
    logic [OCC_W-1:0]    occupancy;
    logic                credit_ok;
    logic                issue;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                pipe_empty;
    logic                drain_done;
    logic [ENTRY_W-1:0]  head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign desc_start = pointer_addr[ADDR_W-1:0];
    assign desc_len   = pointer_addr[ADDR_W +: LEN_W];

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a value on entry,
        // so no path through the block can leave it holding state (a latch).
        inflight_cnt = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight_cnt = inflight_cnt + OCC_W'(pipe_valid_q[i]);
        end
    end

    // Credit counts reads in flight as already occupying FIFO slots, so a
    // push can never find the FIFO full regardless of consumer behaviour.
    assign occupancy  = inflight_cnt + OCC_W'(fifo_count);
    assign credit_ok  = occupancy < OCC_W'(FIFO_DEPTH);
    assign issue      = (state_q == S_RUN) && credit_ok;

    assign fifo_empty = (fifo_count == '0);
    assign push       = pipe_valid_q[MEM_LAT-1];
    assign pop        = !fifo_empty && out_ready;
    assign pipe_empty = (pipe_valid_q == '0);

    // The line is finished when nothing is in flight and the FIFO either is
    // empty or is handing over its last entry this cycle.
    assign drain_done = pipe_empty &&
                        (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

    assign head            = fifo_mem[rd_ptr_q];
    assign mem_en          = issue;
    assign mem_addr        = addr_q;
    assign out_valid       = !fifo_empty;
    assign out_last        = head[ENTRY_W-1];
    assign lhs             = head[2*CHAR_W-1:CHAR_W];
    assign rhs             = head[CHAR_W-1:0];
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign chars_remaining = remaining_q;
    assign which_state     = state_q;

    // Control: FSM, address/length counters, in-flight pipe, FIFO pointers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge, independent of
        // statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '1;
            remaining_q  <= '0;
            done_q       <= 1'b0;
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count   <= '0;
        end else if (abort && (state_q != S_IDLE)) begin
            // Abort wins over everything: reads still in flight are forgotten
            // so their data is never pushed, and queued pairs are dropped.
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            done_q       <= 1'b0;
            pipe_valid_q <= '0;
            pipe_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count   <= '0;
        end else begin
            done_q <= 1'b0;

            pipe_valid_q[0] <= issue;
            pipe_last_q[0]  <= issue && (remaining_q == LEN_W'(1));
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_last_q[i]  <= pipe_last_q[i-1];
            end

            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= desc_start;
                        remaining_q <= desc_len;
                        if (desc_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        // Address wraps modulo 2^ADDR_W by design.
                        addr_q      <= addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage: entry is {last, lhs, rhs} captured when the read returns.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; fifo_count alone decides
        // which entries are meaningful, so stale contents are never visible.
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pipe_last_q[MEM_LAT-1], mem_dout};
        end
    end

endmodule

// File: tb/tb_line_streamer.sv
// -----------------------------------------------------------------------------
// tb_line_streamer
//
// Directed bench for line_streamer. Two instances share control inputs: dut1
// uses MEM_LAT=1, dut3 uses MEM_LAT=3. Each has a memory model returning a
// fixed function of the address MEM_LAT cycles after mem_en, and a junk word
// otherwise. Negedge monitors log issued addresses, accepted pairs and done
// pulses; scenario tasks compare against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_line_streamer;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int CHAR_W = 8;
    localparam int SNAP_W = 43;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst = 1'b1;
    logic                    start1 = 1'b0;
    logic                    start3 = 1'b0;
    logic                    abort = 1'b0;
    logic                    out_ready = 1'b1;
    logic [LEN_W+ADDR_W-1:0] pointer_addr = '0;

    logic [ADDR_W-1:0]   mem_addr1, mem_addr3;
    logic                mem_en1, mem_en3;
    logic [2*CHAR_W-1:0] mem_dout1, mem_dout3;
    logic                out_valid1, out_valid3;
    logic [CHAR_W-1:0]   lhs1, rhs1, lhs3, rhs3;
    logic                out_last1, out_last3;
    logic                busy1, busy3;
    logic                done1, done3;
    logic [LEN_W-1:0]    rem1, rem3;
    logic [1:0]          state1, state3;

    int checks   = 0;
    int failures = 0;

    line_streamer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CHAR_W(CHAR_W), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .pointer_addr(pointer_addr),
        .mem_addr(mem_addr1), .mem_en(mem_en1), .mem_dout(mem_dout1),
        .out_valid(out_valid1), .out_ready(out_ready), .lhs(lhs1), .rhs(rhs1),
        .out_last(out_last1), .busy(busy1), .done(done1),
        .chars_remaining(rem1), .which_state(state1)
    );

    line_streamer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .CHAR_W(CHAR_W), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort), .pointer_addr(pointer_addr),
        .mem_addr(mem_addr3), .mem_en(mem_en3), .mem_dout(mem_dout3),
        .out_valid(out_valid3), .out_ready(out_ready), .lhs(lhs3), .rhs(rhs3),
        .out_last(out_last3), .busy(busy3), .done(done3),
        .chars_remaining(rem3), .which_state(state3)
    );

    // Memory contents: lhs is the low address byte, rhs a scrambled mix that
    // also depends on the upper address bits.
    function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], 8'h5A ^ {a[9:8], a[5:0]}};
    endfunction

    logic              m1_v = 1'b0;
    logic [ADDR_W-1:0] m1_a = '0;
    always @(posedge clk) begin
        m1_v <= mem_en1;
        m1_a <= mem_addr1;
    end
    assign mem_dout1 = m1_v ? mem_word(m1_a) : 16'hDEAD;

    logic [2:0]        m3_v = '0;
    logic [ADDR_W-1:0] m3_a [3];
    always @(posedge clk) begin
        m3_v    <= {m3_v[1:0], mem_en3};
        m3_a[0] <= mem_addr3;
        m3_a[1] <= m3_a[0];
        m3_a[2] <= m3_a[1];
    end
    assign mem_dout3 = m3_v[2] ? mem_word(m3_a[2]) : 16'hDEAD;

    // Monitors
    logic [16:0]       acc1[$];
    logic [16:0]       acc3[$];
    logic [ADDR_W-1:0] iss1[$];
    logic [ADDR_W-1:0] iss3[$];
    int                done_cnt1  = 0;
    int                max_fifo3  = 0;
    int                hold_viol3 = 0;
    logic              prev_stall3 = 1'b0;
    logic [16:0]       prev_d3 = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid1 && out_ready) acc1.push_back({out_last1, lhs1, rhs1});
            if (mem_en1) iss1.push_back(mem_addr1);
            if (done1) done_cnt1++;
            if (out_valid3 && out_ready) acc3.push_back({out_last3, lhs3, rhs3});
            if (mem_en3) iss3.push_back(mem_addr3);
            if (int'(dut3.fifo_count) > max_fifo3) max_fifo3 = int'(dut3.fifo_count);
            if (prev_stall3 && (!out_valid3 || ({out_last3, lhs3, rhs3} !== prev_d3)))
                hold_viol3++;
            prev_stall3 = out_valid3 && !out_ready;
            prev_d3     = {out_last3, lhs3, rhs3};
        end
    end

    // Snapshot of dut1 outputs; address/data fields zeroed when unqualified
    // (mask_addr also hides mem_addr while mem_en is low).
    function automatic logic [SNAP_W-1:0] snap1(input bit mask_addr);
        logic [ADDR_W-1:0] a;
        a = (mask_addr && !mem_en1) ? '0 : mem_addr1;
        return {mem_en1, a, out_valid1, out_valid1 ? {out_last1, lhs1, rhs1} : 17'h0,
                busy1, done1, rem1, state1};
    endfunction

    function automatic logic [SNAP_W-1:0] pack(input logic en, input logic [ADDR_W-1:0] a,
                                               input logic ov, input logic [16:0] d,
                                               input logic b, input logic dn,
                                               input logic [LEN_W-1:0] r, input logic [1:0] st);
        return {en, a, ov, d, b, dn, r, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done1(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done1) seen = 1'b1;
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [SNAP_W-1:0] exp_s, obs;
        rst = 1'b1;
        repeat (3) tick();
        exp_s = pack(1'b0, '1, 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        obs = snap1(1'b0);
        checks++;
        if (obs !== exp_s) begin
            failures++;
            $display("FAIL reset_dut1: got %h expected %h", obs, exp_s);
        end
        checks++;
        if ({mem_addr3, mem_en3, out_valid3, busy3, done3, rem3, state3} !==
            {10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 2'd0}) begin
            failures++;
            $display("FAIL reset_dut3: got addr=%h en=%b ov=%b busy=%b st=%0d", mem_addr3,
                     mem_en3, out_valid3, busy3, state3);
        end
        rst = 1'b0;
        tick();
        obs = snap1(1'b0);
        checks++;
        if (obs !== exp_s) begin
            failures++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, exp_s);
        end
    endtask

    // Four pairs from 0x010, cycle-by-cycle against the documented timeline.
    task automatic test_single_line();
        logic [SNAP_W-1:0] exp_s, obs;
        logic [16:0]       d;
        logic [1:0]        st;
        out_ready    = 1'b1;
        pointer_addr = {10'd4, 10'h010};
        start1       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            start1 = 1'b0;
            d  = (k >= 3 && k <= 6) ? {(k == 6), mem_word(ADDR_W'(16 + k - 3))} : 17'h0;
            st = (k <= 4) ? 2'd1 : (k <= 6) ? 2'd2 : (k == 7) ? 2'd3 : 2'd0;
            exp_s = pack((k <= 4), (k <= 4) ? ADDR_W'(16 + k - 1) : '0, (k >= 3 && k <= 6), d,
                         (k <= 7), (k == 7), (k <= 4) ? LEN_W'(5 - k) : '0, st);
            obs = snap1(1'b1);
            checks++;
            if (obs !== exp_s) begin
                failures++;
                $display("FAIL single_line_cycle%0d: got %h expected %h", k, obs, exp_s);
            end
        end
    endtask

    task automatic test_zero_len();
        logic [SNAP_W-1:0] exp_s, obs;
        iss1.delete();
        acc1.delete();
        pointer_addr = {10'd0, 10'h055};
        start1       = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            start1 = 1'b0;
            exp_s = pack(1'b0, '0, 1'b0, '0, (k == 1), (k == 1), '0, (k == 1) ? 2'd3 : 2'd0);
            obs = snap1(1'b1);
            checks++;
            if (obs !== exp_s) begin
                failures++;
                $display("FAIL zero_len_cycle%0d: got %h expected %h", k, obs, exp_s);
            end
        end
        checks++;
        if (iss1.size() != 0 || acc1.size() != 0) begin
            failures++;
            $display("FAIL zero_len_traffic: got reads=%0d pairs=%0d expected 0/0",
                     iss1.size(), acc1.size());
        end
    endtask

    task automatic test_wrap();
        bit seen;
        logic [ADDR_W-1:0] a;
        iss1.delete();
        acc1.delete();
        out_ready    = 1'b1;
        pointer_addr = {10'd4, 10'h3FE};
        start1       = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(40, seen);
        checks++;
        if (!seen || iss1.size() != 4 || acc1.size() != 4) begin
            failures++;
            $display("FAIL wrap_counts: got done=%b reads=%0d pairs=%0d expected 1/4/4",
                     seen, iss1.size(), acc1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                a = ADDR_W'(10'h3FE + i);
                checks++;
                if (iss1[i] !== a || acc1[i] !== {(i == 3), mem_word(a)}) begin
                    failures++;
                    $display("FAIL wrap_pair%0d: got addr=%h data=%h expected addr=%h data=%h",
                             i, iss1[i], acc1[i], a, {(i == 3), mem_word(a)});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        int lasts = 0;
        int bad = 0;
        logic [ADDR_W-1:0] a;
        iss3.delete();
        acc3.delete();
        max_fifo3    = 0;
        hold_viol3   = 0;
        pointer_addr = {10'd16, 10'h200};
        start3       = 1'b1;
        tick();
        start3 = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (done3) seen = 1'b1;
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (!seen || acc3.size() != 16 || iss3.size() != 16) begin
            failures++;
            $display("FAIL bp_counts: got done=%b pairs=%0d reads=%0d expected 1/16/16",
                     seen, acc3.size(), iss3.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                a = ADDR_W'(10'h200 + i);
                if (acc3[i][16]) lasts++;
                if (acc3[i] !== {(i == 15), mem_word(a)} || iss3[i] !== a) bad++;
            end
            checks++;
            if (bad != 0 || lasts != 1) begin
                failures++;
                $display("FAIL bp_order: got %0d wrong pairs, %0d last flags; expected 0, 1",
                         bad, lasts);
            end
        end
        checks++;
        if (max_fifo3 > 5) begin
            failures++;
            $display("FAIL bp_fifo_depth: got max %0d expected <= 5", max_fifo3);
        end
        checks++;
        if (hold_viol3 != 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d unstable stalls expected 0", hold_viol3);
        end
    endtask

    task automatic test_abort();
        logic [SNAP_W-1:0] exp_s, obs;
        int  done_before;
        int  stray = 0;
        bit  seen;
        acc1.delete();
        out_ready    = 1'b1;
        pointer_addr = {10'd8, 10'h100};
        start1       = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (4) tick();
        checks++;
        if (acc1.size() != 2 || state1 !== 2'd1) begin
            failures++;
            $display("FAIL abort_setup: got pairs=%0d state=%0d expected 2/1", acc1.size(), state1);
        end
        done_before = done_cnt1;
        abort       = 1'b1;
        out_ready   = 1'b0;
        tick();
        abort = 1'b0;
        exp_s = pack(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        obs = snap1(1'b1);
        checks++;
        if (obs !== exp_s) begin
            failures++;
            $display("FAIL abort_idle: got %h expected %h", obs, exp_s);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid1 || busy1) stray++;
        end
        checks++;
        if (stray != 0 || done_cnt1 != done_before || acc1.size() != 2) begin
            failures++;
            $display("FAIL abort_quiet: got stray=%0d dones=%0d pairs=%0d expected 0/%0d/2",
                     stray, done_cnt1, acc1.size(), done_before);
        end
        acc1.delete();
        pointer_addr = {10'd2, 10'h020};
        start1       = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(30, seen);
        checks++;
        if (!seen || acc1.size() != 2) begin
            failures++;
            $display("FAIL abort_relaunch_count: got done=%b pairs=%0d expected 1/2",
                     seen, acc1.size());
        end else begin
            checks++;
            if (acc1[0] !== {1'b0, mem_word(10'h020)} || acc1[1] !== {1'b1, mem_word(10'h021)}) begin
                failures++;
                $display("FAIL abort_relaunch_data: got %h %h expected %h %h", acc1[0], acc1[1],
                         {1'b0, mem_word(10'h020)}, {1'b1, mem_word(10'h021)});
            end
        end
    endtask

    task automatic test_rst_mid_line();
        logic [SNAP_W-1:0] exp_s, obs;
        bit reached = 1'b0;
        bit seen;
        int done_before;
        int bad = 0;
        out_ready    = 1'b1;
        pointer_addr = {10'd6, 10'h040};
        start1       = 1'b1;
        for (int i = 0; i < 30 && !reached; i++) begin
            tick();
            if (state1 == 2'd2) reached = 1'b1;
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL rst_reach_drain: got state=%0d expected 2", state1);
        end
        done_before = done_cnt1;
        rst = 1'b1;
        tick();
        exp_s = pack(1'b0, '1, 1'b0, '0, 1'b0, 1'b0, '0, 2'd0);
        obs = snap1(1'b0);
        checks++;
        if (obs !== exp_s) begin
            failures++;
            $display("FAIL rst_mid_line: got %h expected %h", obs, exp_s);
        end
        rst = 1'b0;
        tick();
        acc1.delete();
        exp_s = pack(1'b1, 10'h040, 1'b0, '0, 1'b1, 1'b0, 10'd6, 2'd1);
        obs = snap1(1'b1);
        checks++;
        if (obs !== exp_s) begin
            failures++;
            $display("FAIL rst_relaunch: got %h expected %h", obs, exp_s);
        end
        start1 = 1'b0;
        wait_done1(40, seen);
        for (int i = 0; i < acc1.size() && i < 6; i++)
            if (acc1[i] !== {(i == 5), mem_word(ADDR_W'(10'h040 + i))}) bad++;
        checks++;
        if (!seen || acc1.size() != 6 || bad != 0 || done_cnt1 != done_before + 1) begin
            failures++;
            $display("FAIL rst_relaunch_line: got done=%b pairs=%0d bad=%0d dones=%0d expected 1/6/0/%0d",
                     seen, acc1.size(), bad, done_cnt1, done_before + 1);
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_zero_len();
        test_wrap();
        test_backpressure();
        test_abort();
        test_rst_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
